// File: rtl/mux21_arb_pkg.sv
// Shared encodings for the mux21 round-robin arbiter.
package mux21_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux21_w.sv
// Parameterized W-bit combinational 2:1 mux (sel=0 picks a, sel=1 picks b).
module mux21_w
    import mux21_arb_pkg::*;
#(
    parameter int W = 2
) (
    input  logic         sel,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    // Route the selected source straight through.
    always_comb begin
        y = (sel == SEL_B) ? b : a;
    end

endmodule

// File: rtl/mux21_rr_arb.sv
// Round-robin arbiter and burst sequencer for a shared 2:1 mux feeding a
// registered valid/ready output stage. Owner keeps the mux for up to
// MAX_BURST beats, then hands over without a bubble if the other side waits.
module mux21_rr_arb
    import mux21_arb_pkg::*;
#(
    parameter int W         = 2,
    parameter int MAX_BURST = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_a,
    input  logic [W-1:0] data_a,
    output logic         gnt_a,
    input  logic         req_b,
    input  logic [W-1:0] data_b,
    output logic         gnt_b,
    output logic         sel,
    output logic         busy,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

    state_t          state;
    logic            last;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    mux_out;
    logic            req_owner;
    logic            req_other;
    logic            can_load;
    logic            accept;
    logic            exit_grant;

    // Handshake terms derived from the current owner.
    always_comb begin
        req_owner  = (sel == SEL_B) ? req_b : req_a;
        req_other  = (sel == SEL_B) ? req_a : req_b;
        can_load   = !out_valid || out_ready;
        accept     = busy && req_owner && can_load;
        exit_grant = !req_owner || (accept && (cnt == LAST_BEAT));
    end

    assign busy  = (state == SERVE);
    assign gnt_a = accept && (sel == SEL_A);
    assign gnt_b = accept && (sel == SEL_B);

    mux21_w #(.W(W)) u_mux (
        .sel (sel),
        .a   (data_a),
        .b   (data_b),
        .y   (mux_out)
    );

    // Arbiter FSM, burst counter, round-robin history and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sel       <= SEL_A;
            last      <= SEL_B;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            // Output stage: load on accept, otherwise drain when consumed.
            if (accept) begin
                out_data  <= mux_out;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (req_a || req_b) begin
                        if (req_a && req_b) begin
                            sel <= ~last;
                        end else begin
                            sel <= req_b ? SEL_B : SEL_A;
                        end
                        cnt   <= '0;
                        state <= SERVE;
                    end
                end
                SERVE: begin
                    if (accept) begin
                        cnt <= cnt + 1'b1;
                    end
                    // Exit overrides the count update: a new grant starts at 0.
                    if (exit_grant) begin
                        last <= sel;
                        cnt  <= '0;
                        if (req_other) begin
                            sel <= ~sel;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
